freq_readout: RTL and testbench

FREQ_READOUT -- requirements
Module: freq_readout

---
 rtl/freq_readout_pkg.sv | 18 +
 rtl/edge_sync.sv | 19 +
 rtl/freq_readout.sv | 126 ++++++++++++
 tb/tb_freq_readout.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_readout_pkg.sv
// Shared state encoding and counter sizing helpers for the pixel frequency readout.
// The sizing functions are also used to dimension the frequency_module counters.
package freq_readout_pkg;

    localparam logic [1:0] ST_ARM     = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STALL   = 2'd2;

    // Longest half-period worth measuring; beyond this the input is considered stuck.
    function automatic int timeout_cycles(input int clock_freq, input int low_freq);
        return 2 * clock_freq / low_freq;
    endfunction

    function automatic int count_bits(input int clock_freq, input int low_freq);
        return $clog2(timeout_cycles(clock_freq, low_freq));
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus history flop; flags either edge of an asynchronous input.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic toggle
);

    // [0],[1] synchronize, [2] holds the previous synchronized value
    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[1:0], din};
    end

    assign toggle = sr[2] ^ sr[1];

endmodule

// File: rtl/freq_readout.sv
// Measures the half-period of the pixel square wave, averages 2^AVG_LOG2 samples,
// and presents the result through a single-entry valid/ready register.
module freq_readout
    import freq_readout_pkg::*;
#(
    parameter  int CLOCK_FREQ     = 50_000_000,
    parameter  int LOW_FREQ       = 1_000,
    parameter  int AVG_LOG2       = 2,
    localparam int COUNT_BITS     = count_bits(CLOCK_FREQ, LOW_FREQ),
    localparam int TIMEOUT_CYCLES = timeout_cycles(CLOCK_FREQ, LOW_FREQ)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  FREQ_IN,
    input  logic                  READY,
    output logic                  VALID,
    output logic [COUNT_BITS-1:0] PERIOD_OUT,
    output logic                  TIMEOUT,
    output logic                  OVERRUN
);

    localparam int ACC_W = COUNT_BITS + AVG_LOG2;
    localparam int IDX_W = AVG_LOG2 + 1;
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [COUNT_BITS-1:0] CNT_TIMEOUT = COUNT_BITS'(TIMEOUT_CYCLES);

    logic                  toggle;
    logic [1:0]            state;
    logic [COUNT_BITS-1:0] cnt;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      sum;
    logic [IDX_W-1:0]      idx;
    logic                  res_vld;
    logic                  res_to;
    logic [COUNT_BITS-1:0] res_val;
    logic [COUNT_BITS-1:0] res_avg;

    edge_sync u_edge_sync (
        .clk    (CLK),
        .rst_n  (RST_N),
        .din    (FREQ_IN),
        .toggle (toggle)
    );

    assign sum     = acc + ACC_W'(cnt);
    assign res_avg = COUNT_BITS'(sum >> AVG_LOG2);

    // Measurement FSM; a finished result is staged for one cycle in res_*.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_ARM;
            cnt     <= '0;
            acc     <= '0;
            idx     <= '0;
            res_vld <= 1'b0;
            res_to  <= 1'b0;
            res_val <= '0;
        end else begin
            res_vld <= 1'b0;
            if (!EN) begin
                state <= ST_ARM;
                cnt   <= '0;
                acc   <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    ST_ARM, ST_STALL: begin
                        if (toggle) begin
                            state <= ST_MEASURE;
                            cnt   <= COUNT_BITS'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (toggle) begin
                            cnt <= COUNT_BITS'(1);
                            if (idx == LAST_IDX) begin
                                res_vld <= 1'b1;
                                res_to  <= 1'b0;
                                res_val <= res_avg;
                                acc     <= '0;
                                idx     <= '0;
                            end else begin
                                acc <= sum;
                                idx <= idx + IDX_W'(1);
                            end
                        end else if (cnt == CNT_TIMEOUT) begin
                            res_vld <= 1'b1;
                            res_to  <= 1'b1;
                            res_val <= '1;
                            acc     <= '0;
                            idx     <= '0;
                            state   <= ST_STALL;
                        end else begin
                            cnt <= cnt + COUNT_BITS'(1);
                        end
                    end
                    default: state <= ST_ARM;
                endcase
            end
        end
    end

    // Result register: a held, unconsumed result wins over a new one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            VALID      <= 1'b0;
            PERIOD_OUT <= '0;
            TIMEOUT    <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (res_vld) begin
            if (!VALID || READY) begin
                VALID      <= 1'b1;
                PERIOD_OUT <= res_val;
                TIMEOUT    <= res_to;
                if (VALID) OVERRUN <= 1'b0;
            end else begin
                OVERRUN <= 1'b1;
            end
        end else if (VALID && READY) begin
            VALID   <= 1'b0;
            OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_readout.sv
// Randomized and directed checks of freq_readout against a half-period averaging model.
module tb_freq_readout;

    localparam int CF     = 1_000_000;
    localparam int LF     = 3_000;
    localparam int TO_CYC = 2 * CF / LF;
    localparam int CB     = $clog2(TO_CYC);
    localparam int TO_ENC = (1 << 16) | ((1 << CB) - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          freq_in = 1'b0;
    logic          ready = 1'b1;
    logic          valid;
    logic          timeout;
    logic          overrun;
    logic [CB-1:0] period_out;

    int vectors = 0;
    int errors  = 0;
    int q_res[$];   // observed results, encoded {timeout, 16-bit period}

    always #5 clk = ~clk;

    freq_readout #(.CLOCK_FREQ(CF), .LOW_FREQ(LF), .AVG_LOG2(2)) dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .FREQ_IN(freq_in), .READY(ready),
        .VALID(valid), .PERIOD_OUT(period_out), .TIMEOUT(timeout), .OVERRUN(overrun)
    );

    always @(negedge clk)
        if (rst_n && valid && ready) q_res.push_back((int'(timeout) << 16) | int'(period_out));

    function automatic int pk(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; freq_in = 1'b0; en = 1'b1; ready = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        q_res.delete();
    endtask

    // First toggle is the arming edge; each entry is the gap to the next toggle.
    task automatic send(input int hp[$]);
        freq_in = ~freq_in;
        foreach (hp[i]) begin
            wait_cyc(hp[i]);
            freq_in = ~freq_in;
        end
    endtask

    task automatic test_reset;
        do_reset;
        vectors++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b need 0", valid); end
        vectors++; if (period_out !== '0) begin errors++; $display("FAIL reset_period: got %0d need 0", period_out); end
        vectors++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b need 0", timeout); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b need 0", overrun); end
    endtask

    task automatic test_basic;
        do_reset;
        send('{10, 10, 10, 10});
        wait_cyc(10);
        vectors++;
        if (q_res.size() != 1 || pk(q_res, 0) != 10) begin
            errors++; $display("FAIL basic: got n=%0d res=%0h need n=1 res=a", q_res.size(), pk(q_res, 0));
        end
    endtask

    task automatic test_average;
        do_reset;
        send('{10, 12, 10, 12, 10, 10, 10, 11});
        wait_cyc(10);
        vectors++;
        if (q_res.size() != 2 || pk(q_res, 0) != 11) begin
            errors++; $display("FAIL avg_11: got n=%0d res=%0d need n=2 res=11", q_res.size(), pk(q_res, 0));
        end
        vectors++;
        if (pk(q_res, 1) != 10) begin
            errors++; $display("FAIL avg_trunc: got %0d need 10", pk(q_res, 1));
        end
    endtask

    task automatic test_timeout;
        do_reset;
        freq_in = ~freq_in;
        wait_cyc(TO_CYC + 30);
        vectors++;
        if (q_res.size() != 1 || pk(q_res, 0) != TO_ENC) begin
            errors++; $display("FAIL timeout: got n=%0d res=%0h need n=1 res=%0h", q_res.size(), pk(q_res, 0), TO_ENC);
        end
        send('{20, 20, 20, 20});
        wait_cyc(10);
        vectors++;
        if (q_res.size() != 2 || pk(q_res, 1) != 20) begin
            errors++; $display("FAIL after_stall: got n=%0d res=%0h need n=2 res=14", q_res.size(), pk(q_res, 1));
        end
    endtask

    task automatic test_overrun;
        do_reset;
        ready = 1'b0;
        send('{10, 10, 10, 10, 20, 20, 20, 20});
        wait_cyc(10);
        vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b need 1", valid); end
        vectors++; if (period_out !== CB'(10)) begin errors++; $display("FAIL ovr_hold: got %0d need 10", period_out); end
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b need 1", overrun); end
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid: got %b need 0", valid); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b need 0", overrun); end
        ready = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_reset;
        ready = 1'b0;
        send('{10, 10, 10, 10});
        wait_cyc(10);
        send('{15, 15});
        wait_cyc(5);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b0 || period_out !== '0 || timeout !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL async_reset: got v=%b p=%0d t=%b o=%b need all 0", valid, period_out, timeout, overrun);
        end
        freq_in = 1'b0;
        ready = 1'b1;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        q_res.delete();
        send('{15, 15, 15});
        wait_cyc(15);
        vectors++;
        if (q_res.size() != 0) begin
            errors++; $display("FAIL rearm_early: got n=%0d need n=0", q_res.size());
        end
        freq_in = ~freq_in;
        wait_cyc(10);
        vectors++;
        if (q_res.size() != 1 || pk(q_res, 0) != 15) begin
            errors++; $display("FAIL rearm_result: got n=%0d res=%0d need n=1 res=15", q_res.size(), pk(q_res, 0));
        end
    endtask

    task automatic test_freq_module;
        int setting[2] = '{0, 255};
        foreach (setting[k]) begin
            int hp[$];
            do_reset;
            repeat (4) hp.push_back(setting[k] + 1);
            send(hp);
            wait_cyc(10);
            vectors++;
            if (q_res.size() != 1 || pk(q_res, 0) != setting[k] + 1) begin
                errors++; $display("FAIL fm_set%0d: got n=%0d res=%0d need n=1 res=%0d",
                                   setting[k], q_res.size(), pk(q_res, 0), setting[k] + 1);
            end
        end
    endtask

    task automatic test_enable;
        do_reset;
        ready = 1'b0;
        send('{10, 10, 10, 10});
        wait_cyc(10);
        send('{10, 10});
        wait_cyc(3);
        en = 1'b0;
        wait_cyc(5);
        vectors++;
        if (valid !== 1'b1 || period_out !== CB'(10)) begin
            errors++; $display("FAIL en_hold: got v=%b p=%0d need v=1 p=10", valid, period_out);
        end
        en = 1'b1;
        ready = 1'b1;
        wait_cyc(3);
        q_res.delete();
        send('{12, 12, 12, 12});
        wait_cyc(10);
        vectors++;
        if (q_res.size() != 1 || pk(q_res, 0) != 12) begin
            errors++; $display("FAIL en_discard: got n=%0d res=%0d need n=1 res=12", q_res.size(), pk(q_res, 0));
        end
    endtask

    task automatic test_random;
        repeat (6) begin
            int hp[$];
            int exp_q[$];
            int n, acc;
            do_reset;
            n = $urandom_range(4, 11);
            acc = 0;
            for (int i = 0; i < n; i++) begin
                hp.push_back($urandom_range(1, 60));
                acc += hp[i];
                if ((i + 1) % 4 == 0) begin
                    exp_q.push_back(acc / 4);
                    acc = 0;
                end
            end
            send(hp);
            wait_cyc(10);
            vectors++;
            if (q_res.size() != exp_q.size()) begin
                errors++; $display("FAIL rand_count: got %0d need %0d", q_res.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                vectors++;
                if (pk(q_res, i) != exp_q[i]) begin
                    errors++; $display("FAIL rand_result[%0d]: got %0d need %0d", i, pk(q_res, i), exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_average;
        test_timeout;
        test_overrun;
        test_reset_mid;
        test_freq_module;
        test_enable;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
